// File: rtl/tl_pkg.sv
// Shared encodings for the highway/country-road intersection controllers.
package tl_pkg;

    localparam logic [2:0] LED_GREEN  = 3'b100;
    localparam logic [2:0] LED_YELLOW = 3'b010;
    localparam logic [2:0] LED_RED    = 3'b001;

    typedef enum logic [1:0] {
        PH_HW_GREEN  = 2'b00,
        PH_HW_YELLOW = 2'b01,
        PH_CR_GREEN  = 2'b10,
        PH_CR_YELLOW = 2'b11
    } phase_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_HW_GREEN:  next_phase = PH_HW_YELLOW;
            PH_HW_YELLOW: next_phase = PH_CR_GREEN;
            PH_CR_GREEN:  next_phase = PH_CR_YELLOW;
            default:      next_phase = PH_HW_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Timing-tick prescaler: tick once every TICK_DIV clocks, restartable at a phase boundary.
module tl_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    // With TICK_DIV=1 the count is pinned at 0 == LAST, so tick is constantly high.
    always_comb begin
        tick_o = (pre_q == LAST);
        if (restart_i || tick_o) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/hw_phase_master.sv
// Highway-side phase master: owns the phase timer, drives highway lamps,
// and issues the shared time_out strobe and CR_Ena handover request.
module hw_phase_master
    import tl_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned HW_GREEN_MIN = 8,
    parameter int unsigned HW_YELLOW_T  = 3,
    parameter int unsigned CR_GREEN_T   = 5,
    parameter int unsigned CR_YELLOW_T  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_sensor,
    output logic [2:0] hw_led,
    output logic       cr_ena,
    output logic       time_out,
    output logic [1:0] phase
);

    localparam longint unsigned CAP = 64'd1 << CNT_W;

    if (CNT_W < 1 || CNT_W > 32 || TICK_DIV < 1 || TICK_DIV > 65535 ||
        HW_GREEN_MIN < 1 || HW_YELLOW_T < 1 || CR_GREEN_T < 1 || CR_YELLOW_T < 1 ||
        64'(HW_GREEN_MIN) > CAP || 64'(HW_YELLOW_T) > CAP ||
        64'(CR_GREEN_T) > CAP || 64'(CR_YELLOW_T) > CAP) begin : g_param_check
        $error("hw_phase_master: illegal parameter value");
    end

    function automatic logic [CNT_W-1:0] load_val(input phase_e p);
        case (p)
            PH_HW_YELLOW: load_val = CNT_W'(HW_YELLOW_T - 1);
            PH_CR_GREEN:  load_val = CNT_W'(CR_GREEN_T - 1);
            PH_CR_YELLOW: load_val = CNT_W'(CR_YELLOW_T - 1);
            default:      load_val = CNT_W'(HW_GREEN_MIN - 1);
        endcase
    endfunction

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             tick;
    logic             qual;

    tl_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(time_out),
        .tick_o   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= car_sensor;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_HW_GREEN;
            cnt_q   <= load_val(PH_HW_GREEN);
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend only on registered state, never directly on car_sensor.
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        hw_led   = LED_RED;
        cr_ena   = 1'b0;
        qual     = (phase_q == PH_HW_GREEN) ? sync2_q : 1'b1;
        time_out = tick & (cnt_q == '0) & qual;

        case (phase_q)
            PH_HW_GREEN:  hw_led = LED_GREEN;
            PH_HW_YELLOW: begin
                hw_led = LED_YELLOW;
                cr_ena = 1'b1;
            end
            PH_CR_GREEN:  hw_led = LED_RED;
            PH_CR_YELLOW: hw_led = LED_RED;
            default:      hw_led = LED_RED;
        endcase

        if (time_out) begin
            phase_d = next_phase(phase_q);
            cnt_d   = load_val(phase_d);
        end else if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign phase = phase_q;

endmodule
